// File: rtl/imem_boot_sequencer_pkg.sv
// rtl/imem_boot_sequencer_pkg.sv - shared boot sequencer states, stride and hold default
package imem_boot_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } boot_state_e;

    localparam int unsigned BYTE_STRIDE         = 4;
    localparam int unsigned HOLD_CYCLES_DEFAULT = 4;

    function automatic logic [31:0] word_to_byte_addr(input logic [7:0] idx);
        return 32'(idx) * BYTE_STRIDE;
    endfunction

endpackage

// File: rtl/imem_boot_sequencer_hold_timer.sv
// rtl/imem_boot_sequencer_hold_timer.sv - countdown that times the CPU reset hold
module boot_hold_timer
    import imem_boot_sequencer_pkg::*;
#(
    parameter int unsigned CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic cnt_en,
    output logic expired
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= 4'(CYCLES);
        end else if (cnt_en && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Flags the final hold cycle so the FSM leaves HOLD on this edge.
    assign expired = (cnt == 4'd1);

endmodule

// File: rtl/imem_boot_sequencer.sv
// rtl/imem_boot_sequencer.sv - streams a program into CPU instruction memory, then releases reset
module imem_boot_sequencer
    import imem_boot_sequencer_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 64,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        initialize,
    output logic [31:0] instruction_initialize_data,
    output logic [31:0] instruction_initialize_address,
    output logic        cpu_rst,
    output logic        done,
    output logic        error,
    output logic [7:0]  word_count
);

    boot_state_e state;
    logic        accept;
    logic        last_slot;
    logic        finish;
    logic        hold_expired;

    assign accept    = (state == ST_LOAD) && load_valid && load_ready;
    assign last_slot = (word_count == 8'(MEM_WORDS - 1));
    assign finish    = accept && (load_last || last_slot);

    boot_hold_timer #(
        .CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (finish),
        .cnt_en  (state == ST_HOLD),
        .expired (hold_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                          <= ST_IDLE;
            load_ready                     <= 1'b0;
            initialize                     <= 1'b1;
            cpu_rst                        <= 1'b1;
            done                           <= 1'b0;
            error                          <= 1'b0;
            word_count                     <= 8'd0;
            instruction_initialize_data    <= 32'd0;
            instruction_initialize_address <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state                          <= ST_LOAD;
                        load_ready                     <= 1'b1;
                        word_count                     <= 8'd0;
                        instruction_initialize_address <= 32'd0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        instruction_initialize_data    <= load_data;
                        instruction_initialize_address <= word_to_byte_addr(word_count);
                        if (word_count != 8'(MEM_WORDS))
                            word_count <= word_count + 8'd1;
                        if (finish) begin
                            state      <= ST_HOLD;
                            load_ready <= 1'b0;
                            // Filling the last slot without a last marker means the program overflowed.
                            if (!load_last)
                                error <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_expired) begin
                        state      <= ST_RUN;
                        initialize <= 1'b0;
                        cpu_rst    <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        state                          <= ST_LOAD;
                        load_ready                     <= 1'b1;
                        initialize                     <= 1'b1;
                        cpu_rst                        <= 1'b1;
                        done                           <= 1'b0;
                        error                          <= 1'b0;
                        word_count                     <= 8'd0;
                        instruction_initialize_address <= 32'd0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
